motor_mixer: RTL and testbench

//  Rate-to-motor consumer of the body-frame rate controller handshake. On each rising edge of

---
 rtl/motor_mixer_pkg.sv | 46 ++++
 rtl/motor_mixer_sum_clamp.sv | 45 ++++
 rtl/motor_mixer.sv | 164 ++++++++++++++++
 tb/tb_motor_mixer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_mixer_pkg.sv
// Shared definitions for the quad-X motor mixer: one-hot FSM encodings, the per-motor
// {P,R,Y} sign table and default command limits. Optional feature macro: MOTOR_SLEW_LIMIT_EN.
package motor_mixer_pkg;

   localparam int MOTOR_MIN_DEF     = 0;
   localparam int MOTOR_MAX_DEF     = 1000;
   localparam int THROTTLE_IDLE_DEF = 50;

`ifdef MOTOR_SLEW_LIMIT_EN
   localparam int SLEW_MAX_DEF = 40;

   typedef enum logic [7:0] {
      S_IDLE   = 8'b0000_0001,
      S_LATCH  = 8'b0000_0010,
      S_MIX0   = 8'b0000_0100,
      S_MIX1   = 8'b0000_1000,
      S_MIX2   = 8'b0001_0000,
      S_MIX3   = 8'b0010_0000,
      S_SLEW   = 8'b0100_0000,
      S_COMMIT = 8'b1000_0000
   } mixer_state_e;
`else
   typedef enum logic [6:0] {
      S_IDLE   = 7'b000_0001,
      S_LATCH  = 7'b000_0010,
      S_MIX0   = 7'b000_0100,
      S_MIX1   = 7'b000_1000,
      S_MIX2   = 7'b001_0000,
      S_MIX3   = 7'b010_0000,
      S_COMMIT = 7'b100_0000
   } mixer_state_e;
`endif

   // Returns {P,R,Y} subtract flags for motor idx (0=FL, 1=FR, 2=RR, 3=RL).
   function automatic logic [2:0] mix_sign(input logic [1:0] idx);
      logic [2:0] s;
      case (idx)
         2'd0:    s = 3'b001; // T+P+R-Y
         2'd1:    s = 3'b010; // T+P-R+Y
         2'd2:    s = 3'b111; // T-P-R-Y
         default: s = 3'b100; // T-P+R+Y
      endcase
      return s;
   endfunction

endpackage

// File: rtl/motor_mixer_sum_clamp.sv
// Combinational T +/- P +/- R +/- Y for one motor: drops rate fraction bits by arithmetic
// shift, sums in MOTOR_W+2 signed bits and saturates to [MOTOR_MIN, MOTOR_MAX].
module motor_mixer_sum_clamp #(
   parameter int RATE_W     = 16,
   parameter int THROTTLE_W = 16,
   parameter int MOTOR_W    = 16,
   parameter int FRAC_BITS  = 4,
   parameter int MOTOR_MIN  = 0,
   parameter int MOTOR_MAX  = 1000
) (
   input  logic        [THROTTLE_W-1:0] thr_i,
   input  logic signed [RATE_W-1:0]     pitch_i,
   input  logic signed [RATE_W-1:0]     roll_i,
   input  logic signed [RATE_W-1:0]     yaw_i,
   input  logic        [2:0]            neg_i,
   output logic        [MOTOR_W-1:0]    motor_o
);

   localparam int SW = MOTOR_W + 2;
   localparam logic signed [SW-1:0] MIN_S = SW'(MOTOR_MIN);
   localparam logic signed [SW-1:0] MAX_S = SW'(MOTOR_MAX);

   logic signed [RATE_W-1:0] p_sh, r_sh, y_sh;
   logic signed [SW-1:0]     t_ext, p_ext, r_ext, y_ext, sum;

   always_comb begin
      p_sh  = pitch_i >>> FRAC_BITS;
      r_sh  = roll_i  >>> FRAC_BITS;
      y_sh  = yaw_i   >>> FRAC_BITS;
      t_ext = {{(SW-THROTTLE_W){1'b0}}, thr_i};
      p_ext = {{(SW-RATE_W){p_sh[RATE_W-1]}}, p_sh};
      r_ext = {{(SW-RATE_W){r_sh[RATE_W-1]}}, r_sh};
      y_ext = {{(SW-RATE_W){y_sh[RATE_W-1]}}, y_sh};
      sum   = t_ext + (neg_i[2] ? -p_ext : p_ext)
                    + (neg_i[1] ? -r_ext : r_ext)
                    + (neg_i[0] ? -y_ext : y_ext);
      if (sum < MIN_S)
         motor_o = MOTOR_W'(MOTOR_MIN);
      else if (sum > MAX_S)
         motor_o = MOTOR_W'(MOTOR_MAX);
      else
         motor_o = sum[MOTOR_W-1:0];
   end

endmodule

// File: rtl/motor_mixer.sv
// Quad-X rate-to-motor mixer: latches throttle/rates on a rates_valid rising edge, mixes one
// motor per cycle through a shared sum/clamp and commits all four at once. Macro: MOTOR_SLEW_LIMIT_EN.
module motor_mixer
   import motor_mixer_pkg::*;
#(
   parameter int RATE_W        = 16,
   parameter int THROTTLE_W    = 16,
   parameter int MOTOR_W       = 16,
   parameter int FRAC_BITS     = 4,
   parameter int MOTOR_MIN     = MOTOR_MIN_DEF,
   parameter int MOTOR_MAX     = MOTOR_MAX_DEF,
`ifdef MOTOR_SLEW_LIMIT_EN
   parameter int SLEW_MAX      = SLEW_MAX_DEF,
`endif
   parameter int THROTTLE_IDLE = THROTTLE_IDLE_DEF
) (
   input  logic                  us_clk,
   input  logic                  reset,
   input  logic                  rates_valid,
   input  logic [THROTTLE_W-1:0] throttle_in,
   input  logic [RATE_W-1:0]     yaw_rate_in,
   input  logic [RATE_W-1:0]     roll_rate_in,
   input  logic [RATE_W-1:0]     pitch_rate_in,
   input  logic                  armed,
   output logic [MOTOR_W-1:0]    motor_1,
   output logic [MOTOR_W-1:0]    motor_2,
   output logic [MOTOR_W-1:0]    motor_3,
   output logic [MOTOR_W-1:0]    motor_4,
   output logic                  mixer_busy,
   output logic                  update_done,
   output mixer_state_e          debug_state_o
);

   // Handshake: an update starts only on a rising edge of rates_valid seen in IDLE while
   // armed; a held-high level or an edge during an update is ignored, no back-pressure exists.
   mixer_state_e state_q, state_d;

   logic                  rates_valid_q;
   logic                  start;
   logic [THROTTLE_W-1:0] thr_q;
   logic [RATE_W-1:0]     pitch_q, roll_q, yaw_q;
   logic                  idle_q;
   logic [MOTOR_W-1:0]    stage_q [4];
   logic [MOTOR_W-1:0]    motor_q [4];
   logic                  done_q;
   logic [1:0]            mix_idx;
   logic                  mix_en;
   logic [MOTOR_W-1:0]    mixed;

   assign start = rates_valid & ~rates_valid_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start && armed) state_d = S_LATCH;
         S_LATCH:  state_d = S_MIX0;
         S_MIX0:   state_d = S_MIX1;
         S_MIX1:   state_d = S_MIX2;
         S_MIX2:   state_d = S_MIX3;
`ifdef MOTOR_SLEW_LIMIT_EN
         S_MIX3:   state_d = S_SLEW;
         S_SLEW:   state_d = S_COMMIT;
`else
         S_MIX3:   state_d = S_COMMIT;
`endif
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (!armed) state_d = S_IDLE;
   end

   always_comb begin
      mix_idx = 2'd0;
      mix_en  = 1'b0;
      case (state_q)
         S_MIX0:  begin mix_idx = 2'd0; mix_en = 1'b1; end
         S_MIX1:  begin mix_idx = 2'd1; mix_en = 1'b1; end
         S_MIX2:  begin mix_idx = 2'd2; mix_en = 1'b1; end
         S_MIX3:  begin mix_idx = 2'd3; mix_en = 1'b1; end
         default: ;
      endcase
   end

   motor_mixer_sum_clamp #(
      .RATE_W     (RATE_W),
      .THROTTLE_W (THROTTLE_W),
      .MOTOR_W    (MOTOR_W),
      .FRAC_BITS  (FRAC_BITS),
      .MOTOR_MIN  (MOTOR_MIN),
      .MOTOR_MAX  (MOTOR_MAX)
   ) u_sum_clamp (
      .thr_i   (thr_q),
      .pitch_i (pitch_q),
      .roll_i  (roll_q),
      .yaw_i   (yaw_q),
      .neg_i   (mix_sign(mix_idx)),
      .motor_o (mixed)
   );

`ifdef MOTOR_SLEW_LIMIT_EN
   // Step toward the target by at most SLEW_MAX from the currently driven command.
   function automatic logic [MOTOR_W-1:0] slew_limit(input logic [MOTOR_W-1:0] tgt,
                                                     input logic [MOTOR_W-1:0] prev);
      int t, p;
      t = int'(tgt);
      p = int'(prev);
      if (t > p + SLEW_MAX)      t = p + SLEW_MAX;
      else if (t < p - SLEW_MAX) t = p - SLEW_MAX;
      if (t < MOTOR_MIN)         t = MOTOR_MIN;
      else if (t > MOTOR_MAX)    t = MOTOR_MAX;
      return MOTOR_W'(t);
   endfunction
`endif

   always_ff @(posedge us_clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rates_valid_q <= 1'b0;
         thr_q         <= '0;
         pitch_q       <= '0;
         roll_q        <= '0;
         yaw_q         <= '0;
         idle_q        <= 1'b0;
         done_q        <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            stage_q[i] <= '0;
            motor_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         rates_valid_q <= rates_valid;
         done_q        <= 1'b0;
         if (state_q == S_LATCH) begin
            thr_q   <= throttle_in;
            pitch_q <= pitch_rate_in;
            roll_q  <= roll_rate_in;
            yaw_q   <= yaw_rate_in;
            idle_q  <= (throttle_in < THROTTLE_W'(THROTTLE_IDLE));
         end
         if (mix_en)
            stage_q[mix_idx] <= idle_q ? MOTOR_W'(MOTOR_MIN) : mixed;
`ifdef MOTOR_SLEW_LIMIT_EN
         if (state_q == S_SLEW)
            for (int i = 0; i < 4; i++)
               stage_q[i] <= slew_limit(stage_q[i], motor_q[i]);
`endif
         if (!armed) begin
            for (int i = 0; i < 4; i++) motor_q[i] <= '0;
         end else if (state_q == S_COMMIT) begin
            for (int i = 0; i < 4; i++) motor_q[i] <= stage_q[i];
            done_q <= 1'b1;
         end
      end
   end

   assign motor_1       = motor_q[0];
   assign motor_2       = motor_q[1];
   assign motor_3       = motor_q[2];
   assign motor_4       = motor_q[3];
   assign mixer_busy    = (state_q != S_IDLE);
   assign update_done   = done_q;
   assign debug_state_o = state_q;

endmodule

// File: tb/tb_motor_mixer.sv
// Directed bench for motor_mixer: table of mixing vectors plus hand-written sequences for
// dropped starts, disarm, disarmed start, level hold and mid-update reset.
module tb_motor_mixer;
   import motor_mixer_pkg::*;

`ifdef MOTOR_SLEW_LIMIT_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 6;
`endif

   logic        us_clk;
   logic        reset;
   logic        rates_valid;
   logic [15:0] throttle_in, yaw_rate_in, roll_rate_in, pitch_rate_in;
   logic        armed;
   logic [15:0] motor_1, motor_2, motor_3, motor_4;
   logic        mixer_busy, update_done;
   mixer_state_e dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];

   motor_mixer dut (
      .us_clk        (us_clk),
      .reset         (reset),
      .rates_valid   (rates_valid),
      .throttle_in   (throttle_in),
      .yaw_rate_in   (yaw_rate_in),
      .roll_rate_in  (roll_rate_in),
      .pitch_rate_in (pitch_rate_in),
      .armed         (armed),
      .motor_1       (motor_1),
      .motor_2       (motor_2),
      .motor_3       (motor_3),
      .motor_4       (motor_4),
      .mixer_busy    (mixer_busy),
      .update_done   (update_done),
      .debug_state_o (dbg_state)
   );

   // clock / reset
   initial begin
      us_clk = 1'b0;
      forever #500 us_clk = ~us_clk;
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge us_clk);
      @(negedge us_clk);
      reset = 1'b0;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_motors(input string name, input logic [63:0] e);
      check({name, "_m1"}, int'(motor_1), int'(e[63:48]));
      check({name, "_m2"}, int'(motor_2), int'(e[47:32]));
      check({name, "_m3"}, int'(motor_3), int'(e[31:16]));
      check({name, "_m4"}, int'(motor_4), int'(e[15:0]));
   endtask

   task automatic drive(input logic [15:0] t, input logic [15:0] p,
                        input logic [15:0] r, input logic [15:0] y);
      throttle_in   = t;
      pitch_rate_in = p;
      roll_rate_in  = r;
      yaw_rate_in   = y;
   endtask

   // One full update: rising edge, wait bounded for update_done, score against exp_q.
   task automatic run_update(input string name, input logic [15:0] t, input logic [15:0] p,
                             input logic [15:0] r, input logic [15:0] y);
      int   lat;
      logic got, busy_gap;
      logic [63:0] e;
      lat = -1; got = 1'b0; busy_gap = 1'b0;
      @(negedge us_clk);
      drive(t, p, r, y);
      rates_valid = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge us_clk);
         if (update_done) begin
            got = 1'b1;
            lat = c;
         end else if (!mixer_busy) busy_gap = 1'b1;
      end
      check({name, "_latency"}, lat, LAT);
      check({name, "_busy_gap"}, int'(busy_gap), 0);
      check({name, "_busy_at_done"}, int'(mixer_busy), 0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      check_motors(name, e);
      rates_valid = 1'b0;
      @(negedge us_clk);
      check({name, "_done_width"}, int'(update_done), 0);
   endtask

   typedef struct {
      logic [15:0] t, p, r, y;
      logic [15:0] e1, e2, e3, e4;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int dones;
      rates_valid = 1'b0;
      armed       = 1'b1;
      drive(16'd0, 16'd0, 16'd0, 16'd0);
      do_reset();

      check("rst_m1", int'(motor_1), 0);
      check("rst_m2", int'(motor_2), 0);
      check("rst_m3", int'(motor_3), 0);
      check("rst_m4", int'(motor_4), 0);
      check("rst_busy", int'(mixer_busy), 0);
      check("rst_done", int'(update_done), 0);
      check("rst_state", int'(dbg_state), int'(S_IDLE));

`ifdef MOTOR_SLEW_LIMIT_EN
      exp_q.push_back({16'd40, 16'd40, 16'd40, 16'd40});
      run_update("slew1", 16'd500, 16'd0, 16'd0, 16'd0);
      exp_q.push_back({16'd80, 16'd80, 16'd80, 16'd80});
      run_update("slew2", 16'd500, 16'd0, 16'd0, 16'd0);
`else
      vecs[0] = '{16'd500,  16'h0000, 16'h0000, 16'h0000, 16'd500,  16'd500, 16'd500,  16'd500};
      vecs[1] = '{16'd500,  16'h0640, 16'h0000, 16'h0000, 16'd600,  16'd600, 16'd400,  16'd400};
      vecs[2] = '{16'd950,  16'h0000, 16'h0320, 16'hFCE0, 16'd1000, 16'd850, 16'd950,  16'd950};
      vecs[3] = '{16'd30,   16'h0640, 16'h0000, 16'h0000, 16'd0,    16'd0,   16'd0,    16'd0};
      vecs[4] = '{16'd500,  16'hE0C0, 16'h0000, 16'h0000, 16'd0,    16'd0,   16'd1000, 16'd1000};
      vecs[5] = '{16'd50,   16'h0000, 16'h0000, 16'h0000, 16'd50,   16'd50,  16'd50,   16'd50};
      vecs[6] = '{16'd49,   16'h0000, 16'h0320, 16'h0000, 16'd0,    16'd0,   16'd0,    16'd0};
      vecs[7] = '{16'd500,  16'h0000, 16'h0000, 16'hFFFF, 16'd501,  16'd499, 16'd501,  16'd499};
      vecs[8] = '{16'd2000, 16'h0000, 16'h0000, 16'h0000, 16'd1000, 16'd1000, 16'd1000, 16'd1000};
      vecs[9] = '{16'd300,  16'h0320, 16'h0190, 16'h00A0, 16'd365,  16'd335, 16'd215,  16'd285};

      for (int i = 0; i < 10; i++) begin
         exp_q.push_back({vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4});
         run_update($sformatf("vec%0d", i), vecs[i].t, vecs[i].p, vecs[i].r, vecs[i].y);
      end

      // Second rising edge during an update is dropped; latched data is used.
      dones = 0;
      @(negedge us_clk);
      drive(16'd400, 16'd0, 16'd0, 16'd0);
      rates_valid = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge us_clk);
         if (c == 2) rates_valid = 1'b0;
         if (c == 3) begin
            rates_valid = 1'b1;
            drive(16'd800, 16'h0640, 16'd0, 16'd0);
         end
         if (update_done) begin
            dones++;
            check("drop_latency", c, LAT);
            check_motors("drop", {16'd400, 16'd400, 16'd400, 16'd400});
         end
      end
      check("drop_done_count", dones, 1);
      check("drop_level_no_retrigger", int'(mixer_busy), 0);
      rates_valid = 1'b0;

      // Disarm mid-update: motors zero next edge, FSM idle, no done pulse.
      dones = 0;
      @(negedge us_clk);
      drive(16'd700, 16'd0, 16'd0, 16'd0);
      rates_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge us_clk);
         if (c == 2) armed = 1'b0;
         if (c == 3) begin
            check_motors("disarm", 64'd0);
            check("disarm_busy", int'(mixer_busy), 0);
         end
         if (update_done) dones++;
      end
      check("disarm_done_count", dones, 0);

      // Rising edge while disarmed is ignored; re-arming with level held does not start.
      rates_valid = 1'b0;
      @(negedge us_clk);
      rates_valid = 1'b1;
      @(negedge us_clk);
      check("disarmed_start_busy", int'(mixer_busy), 0);
      armed = 1'b1;
      repeat (3) @(negedge us_clk);
      check("rearm_level_busy", int'(mixer_busy), 0);
      check("rearm_level_m1", int'(motor_1), 0);
      rates_valid = 1'b0;

      exp_q.push_back({16'd600, 16'd600, 16'd600, 16'd600});
      run_update("pre_reset", 16'd600, 16'd0, 16'd0, 16'd0);

      // Reset mid-update discards staged data.
      dones = 0;
      @(negedge us_clk);
      drive(16'd900, 16'd0, 16'd0, 16'd0);
      rates_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge us_clk);
         if (c == 2) begin
            reset       = 1'b1;
            rates_valid = 1'b0;
         end
         if (c == 3) begin
            check_motors("midreset", 64'd0);
            check("midreset_busy", int'(mixer_busy), 0);
            reset = 1'b0;
         end
         if (update_done) dones++;
      end
      check("midreset_done_count", dones, 0);

      exp_q.push_back({16'd250, 16'd250, 16'd250, 16'd250});
      run_update("post_reset", 16'd250, 16'd0, 16'd0, 16'd0);
`endif

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
